// File: rtl/cpu_pkg.sv
// Shared core constants: instruction width, default fetch address width and
// the opcode encodings used by decode/branch consumers.
package cpu_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned OP_W    = 6;

    typedef enum logic [OP_W-1:0] {
        OP_R   = 6'h00,
        OP_J   = 6'h02,
        OP_BEQ = 6'h04,
        OP_LI  = 6'h0F,
        OP_LW  = 6'h23,
        OP_SW  = 6'h2B
    } opcode_e;

    function automatic logic [OP_W-1:0] opcode_of(input logic [INSTR_W-1:0] word);
        return word[INSTR_W-1 -: OP_W];
    endfunction

endpackage

// File: rtl/instr_prefetch_unit_pkg.sv
// Prefetch-unit local parameters and the credit counter sizing helper.
package instr_prefetch_unit_pkg;

    localparam int unsigned DEPTH_DEF = 4;

    // Counters must hold 0..DEPTH inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/instr_prefetch_unit_if.sv
// Fetch-side bus bundle: instruction RAM request/response, redirect and decode handshake.
interface instr_prefetch_unit_if #(
    parameter int unsigned ADDR_W = cpu_pkg::ADDR_W
);
    logic                        imem_req_valid;
    logic                        imem_req_ready;
    logic [ADDR_W-1:0]           imem_req_addr;
    logic                        imem_rsp_valid;
    logic [cpu_pkg::INSTR_W-1:0] imem_rsp_data;
    logic                        redirect_valid;
    logic [ADDR_W-1:0]           redirect_pc;
    logic                        inst_valid;
    logic                        inst_ready;
    logic [cpu_pkg::INSTR_W-1:0] inst_data;
    logic [ADDR_W-1:0]           inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/instr_prefetch_unit_fifo.sv
// In-order prefetch buffer: DEPTH entries of {pc, word}, with synchronous flush.
module instr_prefetch_unit_fifo
    import instr_prefetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned WIDTH = 44
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push_i,
    input  logic [WIDTH-1:0]              wdata_i,
    input  logic                          pop_i,
    input  logic                          flush_i,
    output logic [WIDTH-1:0]              rdata_o,
    output logic [cnt_width(DEPTH)-1:0]   count_o,
    output logic                          full_o,
    output logic                          empty_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full buffer is only honoured when the head leaves the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/instr_prefetch_unit.sv
// Fetch stage: credit-limited instruction RAM reads, in-order buffering with PC,
// and redirect flush that discards every response already in flight.
module instr_prefetch_unit
    import instr_prefetch_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W   = cpu_pkg::ADDR_W,
    parameter int unsigned       DEPTH    = DEPTH_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic                  clk,
    input logic                  rst_n,
    instr_prefetch_unit_if.master bus
);
    localparam int unsigned INSTR_W = cpu_pkg::INSTR_W;
    localparam int unsigned CNT_W   = cnt_width(DEPTH);
    localparam int unsigned SUM_W   = CNT_W + 1;
    localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;

    logic                rst_done_q;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]   rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]    outstanding_q, outstanding_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]  fifo_rdata;

    logic req_valid_c, req_hs, rsp_drop, push, pop, redirect;

    assign redirect = bus.redirect_valid;

    // Buffered plus in-flight words never exceed DEPTH, so a response always has a slot.
    assign req_valid_c = rst_done_q &&
                         ((SUM_W'(fifo_count) + SUM_W'(outstanding_q)) < SUM_W'(DEPTH));
    assign req_hs      = req_valid_c && bus.imem_req_ready;
    assign rsp_drop    = bus.imem_rsp_valid && (drop_cnt_q != '0);
    assign push        = bus.imem_rsp_valid && (drop_cnt_q == '0) && !redirect;
    assign pop         = !fifo_empty && bus.inst_ready && !redirect;

    assign bus.imem_req_valid = req_valid_c;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.inst_valid     = !fifo_empty;
    assign {bus.inst_pc, bus.inst_data} = fifo_rdata;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q + CNT_W'(req_hs) - CNT_W'(bus.imem_rsp_valid);
        if (redirect) begin
            // Everything still owed by the RAM after this edge belongs to the old stream.
            fetch_pc_d = bus.redirect_pc;
            rsp_pc_d   = bus.redirect_pc;
            drop_cnt_d = outstanding_d;
        end else begin
            if (req_hs)   fetch_pc_d = fetch_pc_q + ADDR_W'(1);
            if (push)     rsp_pc_d   = rsp_pc_q + ADDR_W'(1);
            if (rsp_drop) drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done_q    <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            rst_done_q    <= 1'b1;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    instr_prefetch_unit_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i ({rsp_pc_q, bus.imem_rsp_data}),
        .pop_i   (pop),
        .flush_i (redirect),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && fifo_full && !pop));
    a_drop_bound: assert property (@(posedge clk) disable iff (!rst_n)
        drop_cnt_q <= outstanding_q);

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Scoreboard bench for instr_prefetch_unit: one RESET_PC=0 instance with a variable-latency
// RAM model, one RESET_PC=0xFFE instance with a 1-cycle RAM to exercise PC wrap.
module tb_instr_prefetch_unit;

    localparam int unsigned AW       = 12;
    localparam int unsigned SB_FILL  = 64;
    localparam logic [AW-1:0] RST_PC_B = 12'hFFE;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [31:0]   data;
    } inst_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   due;
    } ram_ent_t;

    logic clk = 1'b0;
    logic rst_n, rst_n_b;
    always #5 clk = ~clk;

    instr_prefetch_unit_if #(.ADDR_W(AW)) bus_a ();
    instr_prefetch_unit_if #(.ADDR_W(AW)) bus_b ();

    instr_prefetch_unit #(.ADDR_W(AW), .DEPTH(4), .RESET_PC(12'h000)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.master));
    instr_prefetch_unit #(.ADDR_W(AW), .DEPTH(4), .RESET_PC(RST_PC_B)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .bus(bus_b.master));

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return 32'hA5C3_0000 ^ {20'h0, a} ^ {a, 20'h0};
    endfunction

    // Scoreboards
    inst_t         exp_a[$];
    logic [AW-1:0] exp_req_a[$];
    inst_t         exp_b[$];
    inst_t         e_a, e_b;

    function automatic void sb_fill_a(input logic [AW-1:0] start);
        logic [AW-1:0] p;
        exp_a.delete();
        exp_req_a.delete();
        for (int i = 0; i < SB_FILL; i++) begin
            p = start + AW'(i);
            exp_a.push_back('{pc: p, data: mem_word(p)});
            exp_req_a.push_back(p);
        end
    endfunction

    function automatic void sb_fill_b(input logic [AW-1:0] start);
        logic [AW-1:0] p;
        exp_b.delete();
        for (int i = 0; i < SB_FILL; i++) begin
            p = start + AW'(i);
            exp_b.push_back('{pc: p, data: mem_word(p)});
        end
    endfunction

    // RAM model A: in-order, fixed latency ram_lat (changed only across resets)
    int unsigned ram_lat = 1;
    logic [31:0] cyc = '0;
    ram_ent_t    ram_q[$];
    ram_ent_t    r_e;

    always @(posedge clk) cyc <= cyc + 32'd1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_q.delete();
            bus_a.imem_rsp_valid <= 1'b0;
            bus_a.imem_rsp_data  <= '0;
        end else begin
            if (bus_a.imem_req_valid && bus_a.imem_req_ready)
                ram_q.push_back('{addr: bus_a.imem_req_addr, due: cyc + ram_lat});
            if (ram_q.size() > 0 && ram_q[0].due == cyc + 32'd1) begin
                r_e = ram_q.pop_front();
                bus_a.imem_rsp_valid <= 1'b1;
                bus_a.imem_rsp_data  <= mem_word(r_e.addr);
            end else begin
                bus_a.imem_rsp_valid <= 1'b0;
            end
        end
    end

    // RAM model B: 1-cycle latency
    always @(posedge clk or negedge rst_n_b) begin
        if (!rst_n_b) begin
            bus_b.imem_rsp_valid <= 1'b0;
            bus_b.imem_rsp_data  <= '0;
        end else begin
            bus_b.imem_rsp_valid <= bus_b.imem_req_valid && bus_b.imem_req_ready;
            bus_b.imem_rsp_data  <= mem_word(bus_b.imem_req_addr);
        end
    end

    // Monitor A, sampled mid-cycle
    int hs_cnt, rsp_cnt, pops, ncyc;
    int first_req, first_val;
    logic [AW-1:0] first_pop_pc;
    logic popped_since_redir;
    logic redir_hs, redir_rsp;

    always @(negedge clk) begin
        ncyc++;
        if (!rst_n) begin
            sb_fill_a(12'h000);
            hs_cnt = 0; rsp_cnt = 0; pops = 0;
            first_req = -1; first_val = -1;
            popped_since_redir = 1'b1;
        end else begin
            if (first_req < 0 && bus_a.imem_req_valid) first_req = ncyc;
            if (first_val < 0 && bus_a.inst_valid)     first_val = ncyc;
            if (bus_a.imem_req_valid && bus_a.imem_req_ready) begin
                hs_cnt++;
                check_eq("req_sb_nonempty", 32'(exp_req_a.size() != 0), 32'd1);
                if (exp_req_a.size() != 0)
                    check_eq("req_addr", 32'(bus_a.imem_req_addr), 32'(exp_req_a.pop_front()));
            end
            if (bus_a.imem_rsp_valid) rsp_cnt++;
            if (bus_a.inst_valid && bus_a.inst_ready && !bus_a.redirect_valid) begin
                pops++;
                check_eq("inst_sb_nonempty", 32'(exp_a.size() != 0), 32'd1);
                if (exp_a.size() != 0) begin
                    e_a = exp_a.pop_front();
                    check_eq("inst_pc", 32'(bus_a.inst_pc), 32'(e_a.pc));
                    check_eq("inst_data", bus_a.inst_data, e_a.data);
                end
                if (!popped_since_redir) begin
                    first_pop_pc = bus_a.inst_pc;
                    popped_since_redir = 1'b1;
                end
            end
            if (bus_a.redirect_valid) begin
                redir_hs  = bus_a.imem_req_valid && bus_a.imem_req_ready;
                redir_rsp = bus_a.imem_rsp_valid;
                sb_fill_a(bus_a.redirect_pc);
                popped_since_redir = 1'b0;
            end
        end
    end

    // Monitor B
    int pops_b;
    always @(negedge clk) begin
        if (!rst_n_b) begin
            sb_fill_b(RST_PC_B);
            pops_b = 0;
        end else if (bus_b.inst_valid && bus_b.inst_ready) begin
            pops_b++;
            check_eq("b_sb_nonempty", 32'(exp_b.size() != 0), 32'd1);
            if (exp_b.size() != 0) begin
                e_b = exp_b.pop_front();
                check_eq("b_inst_pc", 32'(bus_b.inst_pc), 32'(e_b.pc));
                check_eq("b_inst_data", bus_b.inst_data, e_b.data);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_valid"},  32'(bus_a.imem_req_valid), 32'd0);
        check_eq({tag, "_inst_valid"}, 32'(bus_a.inst_valid),     32'd0);
        check_eq({tag, "_inst_data"},  bus_a.inst_data,           32'd0);
        check_eq({tag, "_inst_pc"},    32'(bus_a.inst_pc),        32'd0);
    endtask

    task automatic do_reset_a(input string tag);
        @(posedge clk); #1 rst_n = 1'b0;
        #1 check_reset_outputs(tag);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_pops(input string tag, input int target);
        int k;
        k = 0;
        while (pops < target && k < 300) begin
            @(posedge clk);
            k++;
        end
        check_eq(tag, 32'(pops >= target), 32'd1);
    endtask

    task automatic pulse_redirect(input logic [AW-1:0] pc);
        bus_a.redirect_valid = 1'b1;
        bus_a.redirect_pc    = pc;
        @(posedge clk);
        #1 bus_a.redirect_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, k;
        rst_n = 1'b0; rst_n_b = 1'b0;
        bus_a.imem_req_ready = 1'b1; bus_a.redirect_valid = 1'b0;
        bus_a.redirect_pc = '0;      bus_a.inst_ready = 1'b1;
        bus_b.imem_req_ready = 1'b1; bus_b.redirect_valid = 1'b0;
        bus_b.redirect_pc = '0;      bus_b.inst_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("rst0");
        check_eq("rst0_b_inst_valid", 32'(bus_b.inst_valid), 32'd0);
        rst_n = 1'b1; rst_n_b = 1'b1;

        // 1: streaming from 0, 2-cycle request-to-valid latency, one word per cycle
        wait_pops("t1_progress", 18);
        check_eq("t1_latency", 32'(first_val - first_req), 32'd2);
        p0 = pops;
        repeat (16) @(posedge clk);
        check_eq("t1_rate", 32'(pops - p0), 32'd16);

        // 5: second instance starting at 0xFFE wraps through 0
        check_eq("t5_b_progress", 32'(pops_b >= 4), 32'd1);
        #1 bus_b.inst_ready = 1'b0;

        // 2: decode stalled, only DEPTH requests go out
        bus_a.inst_ready = 1'b0;
        do_reset_a("t2rst");
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_eq("t2_req_count",  32'(hs_cnt), 32'd4);
        check_eq("t2_req_valid",  32'(bus_a.imem_req_valid), 32'd0);
        check_eq("t2_inst_valid", 32'(bus_a.inst_valid), 32'd1);
        check_eq("t2_head_pc",    32'(bus_a.inst_pc), 32'd0);
        @(posedge clk); #1 bus_a.inst_ready = 1'b1;
        wait_pops("t2_drain", 8);

        // 3: 3-cycle RAM, redirect with responses in flight
        ram_lat = 3;
        do_reset_a("t3rst");
        for (k = 0; k < 50 && hs_cnt < 3; k++) @(posedge clk);
        check_eq("t3_inflight", 32'(hs_cnt >= 3), 32'd1);
        #1 pulse_redirect(12'h100);
        wait_pops("t3_progress", 6);
        check_eq("t3_first_pc", 32'(first_pop_pc), 32'h100);

        // 4: 1-cycle RAM, redirect coinciding with request handshake and response
        ram_lat = 1;
        do_reset_a("t4rst");
        wait_pops("t4_warm", 5);
        #1 pulse_redirect(12'h200);
        @(negedge clk);
        check_eq("t4_valid_after_redir", 32'(bus_a.inst_valid), 32'd0);
        check_eq("t4_redir_hs",  32'(redir_hs),  32'd1);
        check_eq("t4_redir_rsp", 32'(redir_rsp), 32'd1);
        wait_pops("t4_progress", pops + 6);
        check_eq("t4_first_pc", 32'(first_pop_pc), 32'h200);
        // back-to-back redirects: the second target wins, and it wraps
        @(posedge clk);
        #1 pulse_redirect(12'h300);
        pulse_redirect(12'hFFF);
        wait_pops("t4b_progress", pops + 6);
        check_eq("t4b_first_pc", 32'(first_pop_pc), 32'hFFF);

        // 6: asynchronous reset with two reads outstanding
        ram_lat = 3;
        do_reset_a("t6rst");
        wait_pops("t6_warm", 4);
        for (k = 0; k < 50 && (hs_cnt - rsp_cnt) != 2; k++) @(posedge clk);
        check_eq("t6_two_outstanding", 32'(hs_cnt - rsp_cnt), 32'd2);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("t6mid");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_pops("t6_restart", 8);

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
